approx_ha_mul_pipe: RTL and testbench
=====================================

# approx_ha_mul_pipe

Parametrised, pipelined, runtime-configurable approximate unsigned multiplier built on the half-adder-array partial-product scheme. Each pair of partial-product rows is compressed by a row of W-1 configurable cells (exact HA, OR-sum, A-carry-only, eliminate). The arrays are then summed into a 2W-bit product. The block sits between operand producers and consumers in the approximate-arithmetic datapath, uses valid/ready handshakes, and provides a register-programmed per-cell approximation map so one instance can sweep the accuracy/energy Pareto front without re-synthesis.

## Interface
- W, default 8: operand width; even and at least 4.
- NCELL, derived as (W/2)*(W-1): number of configurable cells.
- AW, derived as $clog2(NCELL): width of the config address.

- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high (decided).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands.
- x  in  W  multiplicand.
- y  in  W  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2W  approximate product.
- cfg_we  in  1  write one cell mode.
- cfg_addr  in  AW  cell index, k*(W-1)+i.
- cfg_data  in  2  cell mode.
- err_clr  in  1  clear the statistics (only with APPROX_MUL_ERRSTAT_EN).
- err_sum  out  32  saturating sum of |exact−p| (only with APPROX_MUL_ERRSTAT_EN).
- err_max  out  2W  largest |exact−p| observed (only with APPROX_MUL_ERRSTAT_EN).
- err_cnt  out  32  saturating count of products delivered (only with APPROX_MUL_ERRSTAT_EN).

## Operation
- **Arrays.** Array k (k = 0..W/2-1) uses the following rows:
  - a[j] = y[j]&x[2k]
  - b[j] = y[j]&x[2k+1]
- **Cells.** Cell i (i = 0..W-2) combines a[i+1] and b[i] into a sum s_i (weight i+1) and a carry c_i (weight i+2).
- **Array outputs.**
  - t[0] = a[0]
  - t[i+1] = s_i
  - t[W] = c_{W-2}
  - bo[i] = c_i for i < W-2
  - bo[W-2] = b[W-1]
- **Array value.** V_k = t + (bo << 2). Product p = Σ V_k << 2k, truncated mod 2^(2W).
- **Cell modes:**
  - 00: exact HA, {c,s} = a+b.
  - 01: OR-sum, s = a|b, c = 0.
  - 10: A-carry-only, s = 0, c = a.
  - 11: eliminate, s = c = 0.
- **Mode map.**
  - NCELL×2-bit register.
  - Reset value: all 00, so the block is an exact multiplier after reset.
  - A write with cfg_addr ≥ NCELL is ignored.
- **Config timing.** Cell modes are sampled in stage 1. A write in cycle n applies to operands accepted in cycle n+1 or later. It never affects operands already in flight.
- **Pipeline.**
  - S1 registers the W/2 array outputs.
  - S2 registers the summed p.
  - Both stages hold while stalled.
- **Handshake.**
  - Transfer occurs when valid&&ready.
  - in_ready = !(s1_valid && s2_valid && !out_ready).
  - Once asserted, out_valid and p stay stable until the transfer completes.

## Timing
- Latency: operands accepted in cycle n appear with out_valid in cycle n+2 when out_ready is held high.
- Throughput: one product per cycle.
- Stall: a full pipeline holds both stages; in_ready drops in the same cycle.
- Simultaneous out transfer and input accept while full: allowed, no bubble.
- Reset:
  - out_valid = 0, stage valids = 0, p = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Mode map returns to all-exact.
  - Statistics are cleared to 0.
  - Reset mid-operation discards in-flight products.

## Configuration
- APPROX_MUL_ERRSTAT_EN **defined:**
  - Stage 1 also carries the exact product x*y.
  - At each output transfer: err_sum += |exact−p| (saturating at 2^32−1), err_cnt += 1 (saturating), and err_max = max(err_max, |exact−p|).
  - err_clr zeroes all three next cycle. A transfer in the same cycle as err_clr is not counted.
- APPROX_MUL_ERRSTAT_EN **undefined:** the exact path, the statistics logic and err_clr/err_sum/err_max/err_cnt are all absent.

## Structure
- Package approx_mul_pkg holds:
  - the mode enum (MODE_EXACT, MODE_OR, MODE_ACARRY, MODE_ELIM)
  - the function computing cell index from k and i
  - the saturation limit constant
- Sub-module approx_ha_row, parametrised by W: one combinational compression row (inputs a, b and W-1 modes; outputs t, bo). It is instantiated W/2 times.

## Test plan
- Reset, all-exact, W=8: x=255, y=255 accepted in cycle n → p=65025 with out_valid in cycle n+2; x=0, y=0 → p=0.
- All cells OR (01): x=3, y=3 → p=7 (exact 9). With APPROX_MUL_ERRSTAT_EN: err_sum=2, err_max=2, err_cnt=1.
- Only cell 0 of array 0 set to A-carry (10): x=1, y=2 → p=4. Same cell set to eliminate (11): → p=0.
- cfg write in the same cycle as accepting x=3, y=3 (all OR → exact): that product is 7; next accepted 3×3 → 9.
- Backpressure: 4 back-to-back operands with out_ready low for 3 cycles → in_ready drops once two are held; all 4 products delivered in order, none lost or duplicated.
- Reset asserted with 2 products in flight → out_valid=0 next cycle, no stale product emitted, modes back to exact (x=3, y=3 → 9).

Source files
------------

// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared types and constants for the approximate half-adder-array multiplier
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'b00,
    MODE_OR     = 2'b01,
    MODE_ACARRY = 2'b10,
    MODE_ELIM   = 2'b11
  } mode_t;

  localparam logic [31:0] SAT_LIMIT = 32'hffff_ffff;

  // Flat mode-map index of cell i in compression row k for operand width w.
  function automatic int cell_index(input int w, input int k, input int i);
    return k * (w - 1) + i;
  endfunction

endpackage

// File: rtl/approx_ha_row.sv
// rtl/approx_ha_row.sv - one combinational row of W-1 configurable half-adder cells
module approx_ha_row
  import approx_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*(W-1)-1:0] modes,
  output logic [W:0]         t,
  output logic [W-2:0]       bo
);

  logic [W-2:0] s;
  logic [W-2:0] c;

  // Cell i pairs a[i+1] with b[i]: both carry weight i+1.
  always_comb begin
    s = '0;
    c = '0;
    for (int i = 0; i < W - 1; i++) begin
      case (mode_t'(modes[2*i +: 2]))
        MODE_EXACT: begin
          s[i] = a[i+1] ^ b[i];
          c[i] = a[i+1] & b[i];
        end
        MODE_OR:     s[i] = a[i+1] | b[i];
        MODE_ACARRY: c[i] = a[i+1];
        default:     ;
      endcase
    end
  end

  assign t  = {c[W-2], s, a[0]};
  assign bo = {b[W-1], c[W-3:0]};

endmodule

// File: rtl/approx_ha_mul_pipe.sv
// rtl/approx_ha_mul_pipe.sv - two-stage approximate multiplier with per-cell runtime mode map
// Error statistics (exact path, err_* ports) exist only when APPROX_MUL_ERRSTAT_EN is defined.
module approx_ha_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W = 8,
  localparam int NCELL = (W / 2) * (W - 1),
  localparam int AW = $clog2(NCELL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [1:0]     cfg_data
`ifdef APPROX_MUL_ERRSTAT_EN
  ,
  input  logic           err_clr,
  output logic [31:0]    err_sum,
  output logic [2*W-1:0] err_max,
  output logic [31:0]    err_cnt
`endif
);

  localparam int NARR = W / 2;
  localparam int RW = W - 1;
  localparam logic [AW-1:0] NCELL_A = AW'(NCELL);

  mode_t              mode_q [NCELL];
  mode_t              mode_d [NCELL];
  logic [2*NCELL-1:0] mode_flat;

  logic [W:0]   row_t  [NARR];
  logic [W-2:0] row_bo [NARR];

  logic         s1_valid_q, s1_valid_d;
  logic [W:0]   s1_t_q  [NARR];
  logic [W:0]   s1_t_d  [NARR];
  logic [W-2:0] s1_bo_q [NARR];
  logic [W-2:0] s1_bo_d [NARR];

  logic           s2_valid_q, s2_valid_d;
  logic [2*W-1:0] s2_p_q, s2_p_d;
  logic           s2_ready;

  logic [W+1:0]   v_k;
  logic [2*W-1:0] v_ext;
  logic [2*W-1:0] p_sum;

  always_comb begin
    mode_d = mode_q;
    if (cfg_we && (cfg_addr < NCELL_A)) begin
      mode_d[cfg_addr] = mode_t'(cfg_data);
    end
  end

  always_comb begin
    mode_flat = '0;
    for (int n = 0; n < NCELL; n++) begin
      mode_flat[2*n +: 2] = mode_q[n];
    end
  end

  for (genvar k = 0; k < NARR; k++) begin : g_arr
    approx_ha_row #(.W(W)) u_row (
      .a     (y & {W{x[2*k]}}),
      .b     (y & {W{x[2*k+1]}}),
      .modes (mode_flat[2*cell_index(W, k, 0) +: 2*RW]),
      .t     (row_t[k]),
      .bo    (row_bo[k])
    );
  end

  assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);
  assign s2_ready = !s2_valid_q || out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_t_d     = s1_t_q;
    s1_bo_d    = s1_bo_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_t_d  = row_t;
        s1_bo_d = row_bo;
      end
    end
  end

  // Array k is worth t + (bo << 2), placed at weight 2^(2k).
  always_comb begin
    p_sum = '0;
    v_k   = '0;
    v_ext = '0;
    for (int k = 0; k < NARR; k++) begin
      v_k   = {1'b0, s1_t_q[k]} + {1'b0, s1_bo_q[k], 2'b00};
      v_ext = '0;
      v_ext[W+1:0] = v_k;
      p_sum = p_sum + (v_ext << (2 * k));
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_p_d = p_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NCELL; n++) begin
        mode_q[n] <= MODE_EXACT;
      end
      for (int k = 0; k < NARR; k++) begin
        s1_t_q[k]  <= '0;
        s1_bo_q[k] <= '0;
      end
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      s1_t_q     <= s1_t_d;
      s1_bo_q    <= s1_bo_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign p         = s2_p_q;

`ifdef APPROX_MUL_ERRSTAT_EN
  localparam int SUMW = (2 * W > 32) ? 2 * W + 1 : 33;

  logic [2*W-1:0] exact_prod;
  logic [2*W-1:0] s1_exact_q, s1_exact_d;
  logic [2*W-1:0] s2_exact_q, s2_exact_d;
  logic [2*W-1:0] abs_err;
  logic [SUMW-1:0] sum_wide;
  logic [31:0]    err_sum_q, err_sum_d;
  logic [31:0]    err_cnt_q, err_cnt_d;
  logic [2*W-1:0] err_max_q, err_max_d;

  assign exact_prod = (2*W)'(x) * (2*W)'(y);
  assign abs_err    = (s2_exact_q >= s2_p_q) ? (s2_exact_q - s2_p_q) : (s2_p_q - s2_exact_q);

  // The exact product follows its approximate twin through both stages.
  always_comb begin
    s1_exact_d = s1_exact_q;
    s2_exact_d = s2_exact_q;
    if (in_ready && in_valid) begin
      s1_exact_d = exact_prod;
    end
    if (s2_ready && s1_valid_q) begin
      s2_exact_d = s1_exact_q;
    end
  end

  always_comb begin
    err_sum_d = err_sum_q;
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    sum_wide  = SUMW'(err_sum_q) + SUMW'(abs_err);
    if (err_clr) begin
      err_sum_d = '0;
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_valid && out_ready) begin
      err_sum_d = (sum_wide > SUMW'(SAT_LIMIT)) ? SAT_LIMIT : sum_wide[31:0];
      if (err_cnt_q != SAT_LIMIT) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
      if (abs_err > err_max_q) begin
        err_max_d = abs_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exact_q <= '0;
      s2_exact_q <= '0;
      err_sum_q  <= '0;
      err_cnt_q  <= '0;
      err_max_q  <= '0;
    end else begin
      s1_exact_q <= s1_exact_d;
      s2_exact_q <= s2_exact_d;
      err_sum_q  <= err_sum_d;
      err_cnt_q  <= err_cnt_d;
      err_max_q  <= err_max_d;
    end
  end

  assign err_sum = err_sum_q;
  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_approx_ha_mul_pipe.sv
// tb/tb_approx_ha_mul_pipe.sv - directed plus randomized bench for approx_ha_mul_pipe (W=8)
// Statistics checks are compiled in when APPROX_MUL_ERRSTAT_EN is defined.
module tb_approx_ha_mul_pipe;

  localparam int W = 8;
  localparam int NCELL = 28;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   p;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0]    cfg_data;
`ifdef APPROX_MUL_ERRSTAT_EN
  logic          err_clr;
  logic [31:0]   err_sum;
  logic [15:0]   err_max;
  logic [31:0]   err_cnt;
  longint        m_sum, m_max, m_cnt;
`endif

  approx_ha_mul_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
`ifdef APPROX_MUL_ERRSTAT_EN
    ,
    .err_clr   (err_clr),
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          tb_mode [NCELL];
  logic [15:0] exp_q [$];
  longint      ex_q [$];
  int          delivered = 0;
  logic [15:0] last_p;
  logic        last_acc;
  logic        last_in_ready;
  logic        stalled = 1'b0;
  logic [15:0] held_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Weighted sum of cell outputs, straight from the cell/array definitions.
  function automatic logic [15:0] ref_mul(input logic [7:0] xx, input logic [7:0] yy);
    longint total;
    longint v;
    int xa, xb, ab, bb, s, c;
    total = 0;
    for (int k = 0; k < W / 2; k++) begin
      xa = int'(xx[2*k]);
      xb = int'(xx[2*k+1]);
      v  = longint'(int'(yy[0]) & xa);
      for (int i = 0; i < W - 1; i++) begin
        ab = int'(yy[i+1]) & xa;
        bb = int'(yy[i]) & xb;
        case (tb_mode[k*(W-1)+i])
          0:       begin s = (ab + bb) % 2; c = (ab + bb) / 2; end
          1:       begin s = ab | bb; c = 0; end
          2:       begin s = 0; c = ab; end
          default: begin s = 0; c = 0; end
        endcase
        v += (longint'(s) << (i + 1)) + (longint'(c) << (i + 2));
      end
      v += longint'(int'(yy[W-1]) & xb) << W;
      total += v << (2 * k);
    end
    return total[15:0];
  endfunction

  task automatic cycle();
    longint d;
    #1;
    if (stalled) begin
      check("hold_valid", out_valid, 1);
      check("hold_p", p, held_p);
    end
    if (rst) begin
      exp_q.delete();
      ex_q.delete();
      for (int n = 0; n < NCELL; n++) tb_mode[n] = 0;
`ifdef APPROX_MUL_ERRSTAT_EN
      m_sum = 0; m_max = 0; m_cnt = 0;
`endif
      stalled  = 1'b0;
      last_acc = 1'b0;
    end else begin
      last_in_ready = in_ready;
      last_acc      = in_valid && in_ready;
`ifdef APPROX_MUL_ERRSTAT_EN
      if (err_clr) begin
        m_sum = 0; m_max = 0; m_cnt = 0;
      end
`endif
      if (out_valid && out_ready) begin
        check("queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("p_vs_model", p, exp_q[0]);
          last_p = p;
          delivered++;
          d = ex_q[0] - longint'(exp_q[0]);
          if (d < 0) d = -d;
`ifdef APPROX_MUL_ERRSTAT_EN
          if (!err_clr) begin
            m_sum = (m_sum + d > 64'hffff_ffff) ? 64'hffff_ffff : m_sum + d;
            if (m_cnt < 64'hffff_ffff) m_cnt++;
            if (d > m_max) m_max = d;
          end
`endif
          void'(exp_q.pop_front());
          void'(ex_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held_p  = p;
      if (last_acc) begin
        exp_q.push_back(ref_mul(x, y));
        ex_q.push_back(longint'(x) * longint'(y));
      end
      if (cfg_we && (int'(cfg_addr) < NCELL)) tb_mode[cfg_addr] = int'(cfg_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
`ifdef APPROX_MUL_ERRSTAT_EN
    err_clr   = 1'b0;
`endif
  endtask

  task automatic drain();
    idle_inputs();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send(input logic [7:0] xx, input logic [7:0] yy);
    x = xx;
    y = yy;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    check("send_accepted", last_acc, 1);
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = 2'(data);
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic set_all(input int data);
    for (int n = 0; n < NCELL; n++) cfg_write(n, data);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bx [4];
    logic [7:0] by [4];
    int idx;
    int d0;

    rst = 1'b1;
    idle_inputs();
    x = '0; y = '0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef APPROX_MUL_ERRSTAT_EN
    check("rst_err_sum", err_sum, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_max", err_max, 0);
`endif

    // Exact multiplier after reset; two-cycle latency.
    x = 8'd255; y = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    check("lat_accept", last_acc, 1);
    in_valid = 1'b0;
    #1;
    check("lat_n1_valid", out_valid, 0);
    cycle();
    check("lat_n2_valid", out_valid, 1);
    check("lat_n2_p", p, 65025);
    drain();
    check("exact_255", last_p, 65025);
    send(8'd0, 8'd0);
    drain();
    check("exact_0", last_p, 0);

    // All cells OR-sum.
    set_all(1);
`ifdef APPROX_MUL_ERRSTAT_EN
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
`endif
    send(8'd3, 8'd3);
    drain();
    check("or_3x3", last_p, 7);
`ifdef APPROX_MUL_ERRSTAT_EN
    check("or_err_sum", err_sum, 2);
    check("or_err_max", err_max, 2);
    check("or_err_cnt", err_cnt, 1);
`endif

    // Single cell A-carry, then eliminate.
    set_all(0);
    cfg_write(0, 2);
    send(8'd1, 8'd2);
    drain();
    check("acarry_1x2", last_p, 4);
    cfg_write(0, 3);
    send(8'd1, 8'd2);
    drain();
    check("elim_1x2", last_p, 0);

    // Config write in the accept cycle does not touch that operand.
    set_all(1);
    cfg_write(1, 0);
    x = 8'd3; y = 8'd3; in_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 2'd0;
    cycle();
    check("samecyc_accept", last_acc, 1);
    in_valid = 1'b0; cfg_we = 1'b0;
    drain();
    check("samecyc_old_mode", last_p, 7);
    send(8'd3, 8'd3);
    drain();
    check("samecyc_new_mode", last_p, 9);

    // Backpressure with four back-to-back operands.
    for (int n = 0; n < 4; n++) begin
      bx[n] = 8'($urandom);
      by[n] = 8'($urandom);
    end
    d0 = delivered;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      x = bx[idx]; y = by[idx];
      cycle();
      if (c == 2) check("bp_in_ready_drop", last_in_ready, 0);
      else check("bp_in_ready_high", last_in_ready, 1);
      if (last_acc) idx++;
    end
    check("bp_held_count", idx, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1'b1;
      x = bx[idx]; y = by[idx];
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    drain();
    check("bp_delivered", delivered - d0, 4);

    // Reset with two products in flight.
    set_all(1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 8'd3; y = 8'd3;
    cycle();
    x = 8'd5; y = 8'd5;
    cycle();
    in_valid = 1'b0;
    check("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    out_ready = 1'b1;
    cycle();
    check("rst_no_stale", out_valid, 0);
    send(8'd3, 8'd3);
    drain();
    check("rst_modes_exact", last_p, 9);

    // Out-of-range config writes are ignored.
    cfg_write(30, 3);
    cfg_write(31, 1);
    send(8'd255, 8'd255);
    drain();
    check("oob_write_ignored", last_p, 65025);

    // Randomized traffic, modes, backpressure.
    for (int n = 0; n < 300; n++) begin
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = AW'($urandom_range(0, 31));
      cfg_data  = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      x         = 8'($urandom);
      y         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef APPROX_MUL_ERRSTAT_EN
      err_clr   = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end
    drain();
`ifdef APPROX_MUL_ERRSTAT_EN
    check("rand_err_sum", err_sum, m_sum);
    check("rand_err_max", err_max, m_max);
    check("rand_err_cnt", err_cnt, m_cnt);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    #1;
    check("clr_err_sum", err_sum, 0);
    check("clr_err_cnt", err_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
